// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the opcode, picks the immediate format,
// sign-extends to XLEN and queues results in a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam logic [2:0] T_J    = 3'b000;
  localparam logic [2:0] T_U    = 3'b001;
  localparam logic [2:0] T_B    = 3'b010;
  localparam logic [2:0] T_S    = 3'b011;
  localparam logic [2:0] T_I    = 3'b100;
  localparam logic [2:0] T_NONE = 3'b101;

  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;

  logic [1:0]      count;
  logic [XLEN-1:0] e0_imm, e1_imm;
  logic [2:0]      e0_type, e1_type;
  logic            e0_ill, e1_ill;
  logic            acc, drn;

  always_comb begin
    dec_imm32 = '0;
    dec_type  = T_NONE;
    dec_ill   = 1'b0;
    case (instr[6:0])
      7'b0110111, 7'b0010111: begin
        dec_imm32 = {instr[31:12], 12'b0};
        dec_type  = T_U;
      end
      7'b1101111: begin
        dec_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_type  = T_J;
      end
      7'b1100011: begin
        dec_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_type  = T_B;
      end
      7'b0100011: begin
        dec_imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        dec_type  = T_S;
      end
      7'b1100111, 7'b0000011, 7'b1110011: begin
        dec_imm32 = {{21{instr[31]}}, instr[30:20]};
        dec_type  = T_I;
      end
      7'b0010011: begin
        // Shift-immediates carry an unsigned shift amount, not a signed imm
        if (instr[13:12] == 2'b01)
          dec_imm32 = 32'(instr[20 +: SHAMT_W]);
        else
          dec_imm32 = {{21{instr[31]}}, instr[30:20]};
        dec_type = T_I;
      end
      default: dec_ill = 1'b1;
    endcase
    dec_imm       = {XLEN{dec_imm32[31]}};
    dec_imm[31:0] = dec_imm32;
  end

  assign in_ready  = !rst && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count   <= 2'd0;
      e0_imm  <= '0;
      e0_type <= T_NONE;
      e0_ill  <= 1'b0;
      e1_imm  <= '0;
      e1_type <= T_NONE;
      e1_ill  <= 1'b0;
    end else begin
      case ({acc, drn})
        2'b10: begin
          if (count == 2'd0) begin
            e0_imm  <= dec_imm;
            e0_type <= dec_type;
            e0_ill  <= dec_ill;
            count   <= 2'd1;
          end else begin
            e1_imm  <= dec_imm;
            e1_type <= dec_type;
            e1_ill  <= dec_ill;
            count   <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            e0_imm  <= e1_imm;
            e0_type <= e1_type;
            e0_ill  <= e1_ill;
            count   <= 2'd1;
          end else begin
            // Empty buffer presents the idle values
            e0_imm  <= '0;
            e0_type <= T_NONE;
            e0_ill  <= 1'b0;
            count   <= 2'd0;
          end
        end
        2'b11: begin
          e0_imm  <= dec_imm;
          e0_type <= dec_type;
          e0_ill  <= dec_ill;
        end
        default: ;
      endcase
    end
  end

  assign imm      = e0_imm;
  assign imm_type = e0_type;
  assign illegal  = e0_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;
  logic [2:0]  imm_type;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  imm_type64;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm),
    .imm_type(imm_type), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .imm_type(imm_type64), .illegal(illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bb_instr [5] = '{32'h12345037, 32'h008000EF, 32'hFE000FE3, 32'h00112423, 32'h4030D093};
  logic [31:0] bb_imm   [5] = '{32'h12345000, 32'h00000008, 32'hFFFFFFFE, 32'h00000008, 32'h00000003};
  logic [2:0]  bb_type  [5] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_type", 64'(imm_type), 64'd5);
    chk("rst_illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single addi -1
    in_valid = 1'b1; instr = 32'hFFF00093; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(imm), 64'h0000_0000_FFFF_FFFF);
    chk("addi_type", 64'(imm_type), 64'd4);
    chk("addi_illegal", 64'(illegal), 64'd0);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("addi_drained", 64'(out_valid), 64'd0);

    // Back-to-back stream, one result per cycle
    in_valid = 1'b1; instr = bb_instr[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bb%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bb%0d_imm", i), 64'(imm), 64'(bb_imm[i]));
      chk($sformatf("bb%0d_type", i), 64'(imm_type), 64'(bb_type[i]));
      if (i == 2) chk("bb2_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFE);
      if (i < 4) instr = bb_instr[i+1];
      else in_valid = 1'b0;
    end
    tick();
    chk("bb_drained", 64'(out_valid), 64'd0);

    // Stall: two accepted, third held upstream
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h00A00093;
    tick();
    chk("stall_in_ready_full", 64'(in_ready), 64'd0);
    instr = 32'h00F00093;
    tick();
    chk("stall_imm_a", 64'(imm), 64'd5);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("stall_imm_hold", 64'(imm), 64'd5);
    chk("stall_valid_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_b", 64'(imm), 64'd10);
    chk("drain_b_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("drain_c", 64'(imm), 64'd15);
    chk("drain_c_valid", 64'(out_valid), 64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Unknown opcode
    in_valid = 1'b1; instr = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_imm", 64'(imm), 64'd0);
    chk("ill_type", 64'(imm_type), 64'd5);
    chk("ill_flag", 64'(illegal), 64'd1);
    tick();

    // Flush with two entries and an offered input
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h00A00093;
    tick();
    flush = 1'b1; instr = 32'h00F00093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_in_ready", 64'(in_ready), 64'd1);
    chk("flush2_type", 64'(imm_type), 64'd5);
    chk("flush2_imm", 64'(imm), 64'd0);

    // Flush with one entry while in_ready=1: same-cycle accept must be dropped
    in_valid = 1'b1; instr = 32'h00500093;
    tick();
    flush = 1'b1; instr = 32'h00A00093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush1_still_empty", 64'(out_valid), 64'd0);

    // Reset during a stall
    in_valid = 1'b1; instr = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_type", 64'(imm_type), 64'd5);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_valid64", 64'(out_valid64), 64'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_in_ready", 64'(in_ready), 64'd1);
    chk("after_rst_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
